// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and widths for the packet round-robin arbiter.
// Imported by the arbiter top and its priority selector.
package pkt_rr_arbiter_pkg;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pkt_rr_arbiter_rr_select.sv
// Round-robin priority selector: the first requester after ptr wins.
// The input at ptr itself is ranked last.
module rr_select
    import pkt_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    logic          hit;
    logic [IW-1:0] pos;

    // scan from farthest to nearest so the nearest requester wins
    always_comb begin
        hit       = 1'b0;
        pos       = '0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                grant_idx = pos;
                hit       = 1'b1;
            end
        end
        grant_oh = hit ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Merges NUM_IN packet streams onto one output, whole packets at a time,
// round-robin between inputs, paced by the downstream almost-full flag.
module pkt_rr_arbiter
    import pkt_rr_arbiter_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int CNT_W  = 32,
    localparam int GW     = $clog2(NUM_IN)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_IN-1:0][DATA_W-1:0]    in_data,
    input  logic [NUM_IN-1:0]                in_sop,
    input  logic [NUM_IN-1:0]                in_eop,
    input  logic [NUM_IN-1:0]                in_valid,
    input  logic [NUM_IN-1:0][EMPTY_W-1:0]   in_empty,
    output logic [NUM_IN-1:0]                in_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [EMPTY_W-1:0]               out_empty,
    output logic                             out_valid,
    input  logic                             out_almost_full,
    output logic [GW-1:0]                    grant_idx,
    output logic [CNT_W-1:0]                 pkt_cnt
);

    arb_state_t        state;
    logic [GW-1:0]     ptr;
    logic [NUM_IN-1:0] cur_oh;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] win_oh;
    logic [GW-1:0]     win_idx;
    logic              win_any;
    logic              xfer;
    logic              eop_xfer;

    assign cur_oh   = NUM_IN'(1) << grant_idx;
    assign in_ready = (state == SEND) ? cur_oh : '0;
    assign xfer     = (state == SEND) && in_valid[grant_idx];
    assign eop_xfer = xfer && in_eop[grant_idx];
    assign win_any  = |win_oh;

    // while sending, the owner may not win again on its own eop
    assign req = (state == IDLE) ? in_valid : (in_valid & ~cur_oh);

    rr_select #(
        .N  (NUM_IN),
        .IW (GW)
    ) u_rr_select (
        .req       (req),
        .ptr       (ptr),
        .grant_oh  (win_oh),
        .grant_idx (win_idx)
    );

    // arbitration FSM: grant held from first beat until the eop transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            ptr       <= GW'(NUM_IN - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (!out_almost_full && win_any) begin
                        grant_idx <= win_idx;
                        ptr       <= win_idx;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (eop_xfer) begin
                        if (!out_almost_full && win_any) begin
                            grant_idx <= win_idx;
                            ptr       <= win_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // registered framing, zeroed on cycles without a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            pkt_cnt   <= '0;
        end else begin
            out_valid <= xfer;
            out_sop   <= xfer && in_sop[grant_idx];
            out_eop   <= eop_xfer;
            out_empty <= xfer ? in_empty[grant_idx] : '0;
            if (eop_xfer) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

    // wide data path carries no reset; qualified by out_valid
    always_ff @(posedge clk) begin
        if (xfer) begin
            out_data <= in_data[grant_idx];
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Randomized bench for pkt_rr_arbiter against a packet-level model.
// Sources hold whole packets; the model replays the arbitration rules.
module tb_pkt_rr_arbiter;
    import pkt_rr_arbiter_pkg::*;

    localparam int NI = 4;
    localparam int CW = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NI-1:0][DATA_W-1:0]   in_data;
    logic [NI-1:0]               in_sop;
    logic [NI-1:0]               in_eop;
    logic [NI-1:0]               in_valid;
    logic [NI-1:0][EMPTY_W-1:0]  in_empty;
    logic [NI-1:0]               in_ready;
    logic [DATA_W-1:0]           out_data;
    logic                        out_sop;
    logic                        out_eop;
    logic [EMPTY_W-1:0]          out_empty;
    logic                        out_valid;
    logic                        out_almost_full;
    logic [1:0]                  grant_idx;
    logic [CW-1:0]               pkt_cnt;

    pkt_rr_arbiter #(
        .NUM_IN (NI),
        .CNT_W  (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_valid        (in_valid),
        .in_empty        (in_empty),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_empty       (out_empty),
        .out_valid       (out_valid),
        .out_almost_full (out_almost_full),
        .grant_idx       (grant_idx),
        .pkt_cnt         (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // packet sources
    int               pkt_left [NI];
    int               len      [NI];
    int               len_cfg  [NI];
    int               bidx     [NI];
    logic [511:0]     cur_data [NI];
    logic [5:0]       cur_emp  [NI];
    int               prob   = 100;
    bit               af_rand = 1'b0;
    logic             af      = 1'b0;

    // reference model
    int               owner;
    int               last;
    int               e_gidx;
    int               cnt;
    logic             e_valid;
    logic             e_sop;
    logic             e_eop;
    logic [5:0]       e_empty;
    logic [511:0]     e_data;

    int               run     = 0;
    int               max_run = 0;
    int               sop_src [$];

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(logic [NI-1:0] v, int after, int excl);
        for (int k = 1; k <= NI; k++) begin
            int j;
            j = (after + k) % NI;
            if (v[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic new_beat(input int i);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        d[511:504]  = 8'(i);
        cur_data[i] = d;
        cur_emp[i]  = 6'($urandom_range(63));
    endtask

    task automatic load(input int i, input int n, input int l);
        pkt_left[i] = n;
        len_cfg[i]  = l;
        len[i]      = (l == 0) ? int'($urandom_range(4, 1)) : l;
        bidx[i]     = 0;
        new_beat(i);
    endtask

    task automatic src_advance(input int i);
        if (bidx[i] == len[i] - 1) begin
            pkt_left[i]--;
            bidx[i] = 0;
            len[i]  = (len_cfg[i] == 0) ?
                      int'($urandom_range(4, 1)) : len_cfg[i];
        end else begin
            bidx[i]++;
        end
        new_beat(i);
    endtask

    task automatic src_clear();
        for (int i = 0; i < NI; i++) begin
            pkt_left[i] = 0;
            bidx[i]     = 0;
            len[i]      = 1;
            len_cfg[i]  = 1;
        end
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    task automatic model_reset();
        owner   = -1;
        last    = NI - 1;
        e_gidx  = 0;
        cnt     = 0;
        e_valid = 1'b0;
        e_sop   = 1'b0;
        e_eop   = 1'b0;
        e_empty = '0;
    endtask

    // what the arbiter does at the coming edge, given the driven inputs
    task automatic model_edge();
        int w;
        e_valid = 1'b0;
        e_sop   = 1'b0;
        e_eop   = 1'b0;
        e_empty = '0;
        if (owner < 0) begin
            if (!af && |in_valid) begin
                w      = rr_pick(in_valid, last, -1);
                owner  = w;
                last   = w;
                e_gidx = w;
            end
        end else if (in_valid[owner]) begin
            e_valid = 1'b1;
            e_sop   = in_sop[owner];
            e_eop   = in_eop[owner];
            e_empty = in_empty[owner];
            e_data  = in_data[owner];
            src_advance(owner);
            if (e_eop) begin
                cnt = (cnt + 1) % (1 << CW);
                if (af) begin
                    owner = -1;
                end else begin
                    w = rr_pick(in_valid, owner, owner);
                    if (w >= 0) begin
                        owner  = w;
                        last   = w;
                        e_gidx = w;
                    end else begin
                        owner = -1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [NI-1:0] exp_rdy;
        @(negedge clk);
        exp_rdy = (owner < 0) ? '0 : (NI'(1) << owner);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, e_valid);
        chk("out_sop", out_sop, e_sop);
        chk("out_eop", out_eop, e_eop);
        chk("out_empty", out_empty, e_empty);
        chk("grant_idx", grant_idx, e_gidx);
        chk("pkt_cnt", pkt_cnt, cnt);
        if (e_valid) chk("out_data", out_data, e_data);
        if (out_valid && out_sop) sop_src.push_back(int'(out_data[511:504]));
        if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (af_rand) af = ($urandom_range(99) < 25);
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = (pkt_left[i] > 0) && ($urandom_range(99) < prob);
            in_sop[i]   = (bidx[i] == 0);
            in_eop[i]   = (bidx[i] == len[i] - 1);
            in_data[i]  = cur_data[i];
            in_empty[i] = cur_emp[i];
        end
        out_almost_full = af;
        model_edge();
    endtask

    task automatic drain();
        int c;
        bit busy;
        c = 0;
        busy = 1'b1;
        while (busy && c < 3000) begin
            step();
            c++;
            busy = (owner >= 0);
            for (int i = 0; i < NI; i++) if (pkt_left[i] > 0) busy = 1'b1;
        end
        chk("drain_in_budget", busy, 1'b0);
        step();
        step();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        src_clear();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sop_src.delete();
        max_run = 0;
        run     = 0;
    endtask

    initial begin
        int c;
        rst_n           = 1'b0;
        out_almost_full = 1'b0;
        in_data         = '0;
        in_empty        = '0;
        src_clear();
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sop", out_sop, 1'b0);
        chk("rst_out_eop", out_eop, 1'b0);
        chk("rst_out_empty", out_empty, 6'd0);
        chk("rst_in_ready", in_ready, 4'd0);
        chk("rst_grant", grant_idx, 2'd0);
        chk("rst_pkt_cnt", pkt_cnt, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single 3-beat packet on input 0
        load(0, 1, 3);
        drain();
        chk("single_cnt", pkt_cnt, 4'd1);
        chk("single_src", sop_src.size() > 0 ? sop_src[0] : -1, 0);

        // all four inputs, 2-beat packets, back to back
        hard_reset();
        for (int i = 0; i < NI; i++) load(i, 1, 2);
        drain();
        chk("rr_cnt", pkt_cnt, 4'd4);
        chk("rr_npkt", sop_src.size(), 4);
        for (int i = 0; i < NI; i++)
            chk("rr_order", sop_src.size() > i ? sop_src[i] : -1, i);
        chk("rr_contig", max_run, 8);

        // almost-full held from reset blocks arbitration
        hard_reset();
        af = 1'b1;
        for (int i = 0; i < NI; i++) load(i, 1, 2);
        repeat (8) step();
        chk("af_hold_ready", in_ready, 4'd0);
        chk("af_hold_valid", out_valid, 1'b0);
        af = 1'b0;
        step();
        step();
        chk("af_drop_ready", in_ready, 4'b0001);
        drain();

        // almost-full rising mid-packet does not stall the packet
        hard_reset();
        load(2, 2, 4);
        c = 0;
        while (bidx[2] != 1 && c < 50) begin step(); c++; end
        af = 1'b1;
        c = 0;
        while (pkt_left[2] == 2 && c < 50) begin step(); c++; end
        repeat (4) step();
        chk("midaf_ready", in_ready, 4'd0);
        chk("midaf_cnt", pkt_cnt, 4'd1);
        af = 1'b0;
        drain();
        chk("midaf_cnt2", pkt_cnt, 4'd2);

        // asynchronous reset in the middle of a packet on input 1
        hard_reset();
        load(1, 1, 4);
        c = 0;
        while (bidx[1] != 2 && c < 50) begin step(); c++; end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_sop", out_sop, 1'b0);
        chk("arst_eop", out_eop, 1'b0);
        chk("arst_ready", in_ready, 4'd0);
        chk("arst_grant", grant_idx, 2'd0);
        chk("arst_cnt", pkt_cnt, 4'd0);
        src_clear();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sop_src.delete();
        load(0, 1, 2);
        load(1, 1, 2);
        drain();
        chk("arst_first", sop_src.size() > 0 ? sop_src[0] : -1, 0);

        // 17 packets wrap a 4-bit counter to 1
        hard_reset();
        af_rand = 1'b1;
        prob    = 70;
        load(0, 5, 0);
        load(1, 4, 0);
        load(2, 4, 0);
        load(3, 4, 0);
        drain();
        chk("wrap_cnt", pkt_cnt, 4'd1);

        // free-running random traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NI; i++)
                load(i, int'($urandom_range(3, 0)), 0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
